// File: rtl/sprite_pkg.sv
// Shared widths, default parameter values and FSM state type for the sprite ROM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sprite_pkg;

    localparam int ADDR_W = 18;
    localparam int PAL_W  = 5;

    localparam logic [PAL_W-1:0]  DEF_TRANSP_IDX    = 5'd18;
    localparam logic [PAL_W-1:0]  DEF_OVERRUN_IDX   = 5'd18;
    localparam logic [ADDR_W-1:0] DEF_FALLBACK_ADDR = 18'd1704;
    localparam logic [ADDR_W-1:0] DEF_BLANK_ADDR    = 18'd1706;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CHECK = 2'd3
    } state_e;

endpackage

// File: rtl/layer_prio_enc.sv
// Find-first-set over the pending layer mask; bit 0 wins.
// Latency: combinational.
// Backpressure: none.
// Ports: req (pending mask) in; idx (lowest set bit) and found (any bit set) out.
module layer_prio_enc #(
    parameter int NUM_LAYERS = 8,
    parameter int IDX_W      = 3
) (
    input  logic [NUM_LAYERS-1:0] req,
    output logic [IDX_W-1:0]      idx,
    output logic                  found
);

    // Scan from the top so the last hit, the lowest index, wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Arbitrates sprite layers onto one spriteROM port and emits one palette index per pixel.
// Latency: ROM_LAT+2 cycles from pix_strobe to palette_valid, plus ROM_LAT+1 per transparency retry.
// Backpressure: none; a pix_strobe while busy aborts the pixel (OVERRUN_IDX out, overrun_cnt++).
//
// Ports: clk, reset_n (synchronous, active low); pix_strobe/blank/layer_req/layer_addr pixel
// request (sampled on strobe); rom_addr/rom_q ROM port; palette/palette_valid result;
// busy while a pixel is in flight; overrun_cnt saturating abort count.
// Build option: define SPRITE_TRANSP_EN to enable the transparency retry on layer reads.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int                NUM_LAYERS    = 8,
    parameter int                ROM_LAT       = 1,
    parameter logic [PAL_W-1:0]  TRANSP_IDX    = DEF_TRANSP_IDX,
    parameter logic [ADDR_W-1:0] FALLBACK_ADDR = DEF_FALLBACK_ADDR,
    parameter logic [ADDR_W-1:0] BLANK_ADDR    = DEF_BLANK_ADDR,
    parameter logic [PAL_W-1:0]  OVERRUN_IDX   = DEF_OVERRUN_IDX
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         pix_strobe,
    input  logic                         blank,
    input  logic [NUM_LAYERS-1:0]        layer_req,
    input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [PAL_W-1:0]             rom_q,
    output logic [PAL_W-1:0]             palette,
    output logic                         palette_valid,
    output logic                         busy,
    output logic [15:0]                  overrun_cnt
);

    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int CNT_W = $clog2(ROM_LAT + 1);

`ifdef SPRITE_TRANSP_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    state_e                       state;
    logic                         blank_q;
    logic [NUM_LAYERS-1:0]        pend_q;
    logic [NUM_LAYERS*ADDR_W-1:0] addr_q;
    logic                         from_layer_q;
    logic [CNT_W-1:0]             wait_cnt;

    logic [IDX_W-1:0]  enc_idx;
    logic              enc_found;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue_from_layer;
    logic              retry;
    logic              completes;
    logic              do_issue;

    // The bit being read is removed from pend_q at issue time, so pend_q always holds
    // only the lower-priority layers still eligible for a retry.
    layer_prio_enc #(
        .NUM_LAYERS (NUM_LAYERS),
        .IDX_W      (IDX_W)
    ) u_prio (
        .req   (pend_q),
        .idx   (enc_idx),
        .found (enc_found)
    );

    always_comb begin
        issue_addr       = FALLBACK_ADDR;
        issue_from_layer = 1'b0;
        if (!blank_q) begin
            issue_addr = BLANK_ADDR;
        end else if (enc_found) begin
            issue_addr       = addr_q[enc_idx*ADDR_W +: ADDR_W];
            issue_from_layer = 1'b1;
        end
    end

    // Only layer reads retry; blank and fallback reads always complete.
    assign retry     = TRANSP_EN && (state == ST_CHECK) && (rom_q == TRANSP_IDX)
                       && from_layer_q && (|pend_q);
    assign completes = (state == ST_CHECK) && !retry;
    // A retry re-issues straight from CHECK so each extra read costs ROM_LAT+1 cycles.
    assign do_issue  = (state == ST_ISSUE) || retry;

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            blank_q       <= 1'b0;
            pend_q        <= '0;
            addr_q        <= '0;
            from_layer_q  <= 1'b0;
            wait_cnt      <= '0;
            rom_addr      <= '0;
            palette       <= '0;
            palette_valid <= 1'b0;
            overrun_cnt   <= '0;
        end else begin
            palette_valid <= 1'b0;

            if (do_issue) begin
                rom_addr     <= issue_addr;
                from_layer_q <= issue_from_layer;
                if (issue_from_layer) begin
                    pend_q[enc_idx] <= 1'b0;
                end
                wait_cnt <= CNT_W'(ROM_LAT);
                state    <= ST_WAIT;
            end else begin
                case (state)
                    ST_WAIT: begin
                        wait_cnt <= wait_cnt - 1'b1;
                        if (wait_cnt == CNT_W'(1)) begin
                            state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        palette       <= rom_q;
                        palette_valid <= 1'b1;
                        state         <= ST_IDLE;
                    end
                    default: ;
                endcase
            end

            // A new strobe always wins over the FSM step above. It aborts the current
            // pixel unless that pixel completes in this very cycle.
            if (pix_strobe) begin
                if (busy && !completes) begin
                    palette       <= OVERRUN_IDX;
                    palette_valid <= 1'b1;
                    if (overrun_cnt != 16'hFFFF) begin
                        overrun_cnt <= overrun_cnt + 16'd1;
                    end
                end
                blank_q <= blank;
                pend_q  <= layer_req;
                addr_q  <= layer_addr;
                state   <= ST_ISSUE;
            end
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a registered ROM model (ROM_LAT = 1).
// Latency: n/a.
// Backpressure: n/a.
module tb_sprite_rom_arbiter;

    localparam int NL = 8;
`ifdef SPRITE_TRANSP_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             pix_strobe;
    logic             blank;
    logic [NL-1:0]    layer_req;
    logic [NL*18-1:0] layer_addr;
    logic [17:0]      rom_addr;
    logic [4:0]       rom_q;
    logic [4:0]       palette;
    logic             palette_valid;
    logic             busy;
    logic [15:0]      overrun_cnt;

    logic [4:0] rom_val [NL];
    int checks = 0;
    int errors = 0;

    int          lat;
    logic [4:0]  pal;
    logic [17:0] first_addr;
    logic [NL-1:0] seen;
    logic        busy1;

    sprite_rom_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pix_strobe    (pix_strobe),
        .blank         (blank),
        .layer_req     (layer_req),
        .layer_addr    (layer_addr),
        .rom_addr      (rom_addr),
        .rom_q         (rom_q),
        .palette       (palette),
        .palette_valid (palette_valid),
        .busy          (busy),
        .overrun_cnt   (overrun_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] a_of(input int i);
        return 18'h400 + 18'(i);
    endfunction

    function automatic logic [4:0] rom_lookup(input logic [17:0] a);
        logic [4:0] v;
        v = 5'd0;
        if (a == 18'd1706 || a == 18'd1704) v = 5'd18;
        for (int i = 0; i < NL; i++) begin
            if (a == a_of(i)) v = rom_val[i];
        end
        return v;
    endfunction

    always @(posedge clk) rom_q <= rom_lookup(rom_addr);

    task automatic strobe(input logic b, input logic [NL-1:0] req);
        @(negedge clk);
        pix_strobe = 1'b1;
        blank      = b;
        layer_req  = req;
        @(negedge clk);
        pix_strobe = 1'b0;
    endtask

    // Counts cycles (edges) after the strobe edge until palette_valid; lat = 0 on timeout.
    task automatic wait_valid();
        lat  = 0;
        seen = '0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                first_addr = rom_addr;
                busy1      = busy;
            end
            for (int j = 0; j < NL; j++) begin
                if (rom_addr == a_of(j)) seen[j] = 1'b1;
            end
            if (palette_valid) begin
                lat = k;
                pal = palette;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; pix_strobe = 1'b0; blank = 1'b1; layer_req = '0;
        repeat (3) @(negedge clk);
        checks++; if (rom_addr !== 18'd0) begin errors++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
        checks++; if (palette !== 5'd0) begin errors++; $display("FAIL reset_palette got %0d want 0", palette); end
        checks++; if (palette_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", palette_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (overrun_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", overrun_cnt); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_blank();
        strobe(1'b0, 8'hFF);
        wait_valid();
        checks++; if (lat !== 3) begin errors++; $display("FAIL blank_lat got %0d want 3", lat); end
        checks++; if (first_addr !== 18'd1706) begin errors++; $display("FAIL blank_addr got %0d want 1706", first_addr); end
        checks++; if (pal !== 5'd18) begin errors++; $display("FAIL blank_pal got %0d want 18", pal); end
        checks++; if (seen !== 8'h00) begin errors++; $display("FAIL blank_no_layer got %h want 00", seen); end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL blank_busy got %b want 1", busy1); end
        @(negedge clk);
        checks++; if (palette_valid !== 1'b0) begin errors++; $display("FAIL blank_pulse got %b want 0", palette_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL blank_idle got %b want 0", busy); end
    endtask

    task automatic test_fallback();
        strobe(1'b1, 8'h00);
        wait_valid();
        checks++; if (lat !== 3) begin errors++; $display("FAIL fallback_lat got %0d want 3", lat); end
        checks++; if (first_addr !== 18'd1704) begin errors++; $display("FAIL fallback_addr got %0d want 1704", first_addr); end
        checks++; if (pal !== 5'd18) begin errors++; $display("FAIL fallback_pal got %0d want 18", pal); end
    endtask

    task automatic test_priority();
        rom_val[4] = 5'd9;
        strobe(1'b1, 8'b0101_0000);
        wait_valid();
        checks++; if (lat !== 3) begin errors++; $display("FAIL prio_lat got %0d want 3", lat); end
        checks++; if (first_addr !== a_of(4)) begin errors++; $display("FAIL prio_addr got %h want %h", first_addr, a_of(4)); end
        checks++; if (pal !== 5'd9) begin errors++; $display("FAIL prio_pal got %0d want 9", pal); end
    endtask

    task automatic test_transp_chain();
        rom_val[1] = 5'd18;
        rom_val[2] = 5'd7;
        strobe(1'b1, 8'b0000_0110);
        wait_valid();
        checks++; if (lat !== (TEN ? 5 : 3)) begin errors++; $display("FAIL chain_lat got %0d want %0d", lat, TEN ? 5 : 3); end
        checks++; if (first_addr !== a_of(1)) begin errors++; $display("FAIL chain_addr got %h want %h", first_addr, a_of(1)); end
        checks++; if (pal !== (TEN ? 5'd7 : 5'd18)) begin errors++; $display("FAIL chain_pal got %0d want %0d", pal, TEN ? 7 : 18); end
        checks++; if (seen[2] !== TEN) begin errors++; $display("FAIL chain_layer2 got %b want %b", seen[2], TEN); end
    endtask

    task automatic test_overrun();
        rom_val[0] = 5'd18; rom_val[1] = 5'd18; rom_val[2] = 5'd18;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            pix_strobe = 1'b1; blank = 1'b1; layer_req = 8'h07;
            @(negedge clk);
            pix_strobe = 1'b0;
            if (s > 0) begin
                checks++; if (palette_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid%0d got %b want 1", s, palette_valid); end
                checks++; if (palette !== 5'd18) begin errors++; $display("FAIL ovr_pal%0d got %0d want 18", s, palette); end
                checks++; if (overrun_cnt !== 16'(s)) begin errors++; $display("FAIL ovr_cnt%0d got %0d want %0d", s, overrun_cnt, s); end
            end
        end
        wait_valid();
        checks++; if (lat !== (TEN ? 7 : 3)) begin errors++; $display("FAIL ovr_drain_lat got %0d want %0d", lat, TEN ? 7 : 3); end
        // Abort while in ISSUE on a non-transparent layer: the overrun index must win.
        @(negedge clk);
        pix_strobe = 1'b1; layer_req = 8'h10;
        @(negedge clk);
        @(negedge clk);
        pix_strobe = 1'b0;
        checks++; if (palette_valid !== 1'b1 || palette !== 5'd18) begin errors++; $display("FAIL issue_abort got v=%b p=%0d want v=1 p=18", palette_valid, palette); end
        checks++; if (overrun_cnt !== 16'd4) begin errors++; $display("FAIL issue_abort_cnt got %0d want 4", overrun_cnt); end
        wait_valid();
        checks++; if (lat !== 3 || pal !== 5'd9) begin errors++; $display("FAIL issue_abort_next got lat=%0d p=%0d want lat=3 p=9", lat, pal); end
    endtask

    task automatic test_check_strobe();
        rom_val[5] = 5'd11;
        @(negedge clk);
        pix_strobe = 1'b1; blank = 1'b1; layer_req = 8'h10;
        @(negedge clk);
        pix_strobe = 1'b0;
        @(negedge clk);
        @(negedge clk);
        pix_strobe = 1'b1; layer_req = 8'h20;
        @(negedge clk);
        pix_strobe = 1'b0;
        checks++; if (palette_valid !== 1'b1 || palette !== 5'd9) begin errors++; $display("FAIL chk_strobe got v=%b p=%0d want v=1 p=9", palette_valid, palette); end
        checks++; if (overrun_cnt !== 16'd4) begin errors++; $display("FAIL chk_strobe_cnt got %0d want 4", overrun_cnt); end
        wait_valid();
        checks++; if (lat !== 3 || pal !== 5'd11) begin errors++; $display("FAIL chk_strobe_next got lat=%0d p=%0d want lat=3 p=11", lat, pal); end
        checks++; if (first_addr !== a_of(5)) begin errors++; $display("FAIL chk_strobe_addr got %h want %h", first_addr, a_of(5)); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        pix_strobe = 1'b1; blank = 1'b1; layer_req = 8'h10;
        @(negedge clk);
        pix_strobe = 1'b0;
        @(negedge clk);
        reset_n = 1'b0; pix_strobe = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
        checks++; if (rom_addr !== 18'd0) begin errors++; $display("FAIL mid_addr got %0d want 0", rom_addr); end
        checks++; if (palette !== 5'd0 || palette_valid !== 1'b0) begin errors++; $display("FAIL mid_pal got p=%0d v=%b want 0 0", palette, palette_valid); end
        checks++; if (overrun_cnt !== 16'd0) begin errors++; $display("FAIL mid_cnt got %0d want 0", overrun_cnt); end
        reset_n = 1'b1; pix_strobe = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_strobe_ignored got %b want 0", busy); end
        strobe(1'b1, 8'h10);
        wait_valid();
        checks++; if (lat !== 3 || pal !== 5'd9 || first_addr !== a_of(4)) begin errors++; $display("FAIL mid_fresh got lat=%0d p=%0d a=%h want 3 9 %h", lat, pal, first_addr, a_of(4)); end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        pix_strobe = 1'b1; blank = 1'b1; layer_req = 8'h01;
        for (int k = 1; k <= 65540; k++) begin
            @(negedge clk);
            if (k == 1001) begin
                checks++; if (overrun_cnt !== 16'd1000) begin errors++; $display("FAIL sat_mid got %0d want 1000", overrun_cnt); end
            end
            if (k == 65535) begin
                checks++; if (overrun_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h want fffe", overrun_cnt); end
            end
            if (k == 65537 || k == 65540) begin
                checks++; if (overrun_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", overrun_cnt); end
            end
        end
        pix_strobe = 1'b0;
        checks++; if (palette_valid !== 1'b1 || palette !== 5'd18) begin errors++; $display("FAIL sat_abort got v=%b p=%0d want 1 18", palette_valid, palette); end
    endtask

    initial begin
        for (int i = 0; i < NL; i++) begin
            rom_val[i] = 5'd3;
            layer_addr[18*i +: 18] = a_of(i);
        end
        test_reset();
        test_blank();
        test_fallback();
        test_priority();
        test_transp_chain();
        test_overrun();
        test_check_strobe();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
